// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode decoder: removes E0/F0 prefixes and queues one
// {code, extended, released} event per key action in a small FWFT FIFO.
module ps2_scancode_decoder #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    scancode,
  input  logic                          scancode_valid,
  output logic [7:0]                    event_code,
  output logic                          event_extended,
  output logic                          event_released,
  output logic                          event_valid,
  input  logic                          event_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          pending,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } state_t;

  state_t          state, next_state;
  logic [TW-1:0]   to_cnt;
  logic            emit, emit_ext, emit_rel;
  logic            filtered;

  logic [9:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            full, push, pop, push_ok;

  // Bytes that carry no key information (acks, self-test, errors, Pause lead-in)
  always_comb begin
    filtered = 1'b0;
    case (scancode)
      8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: filtered = 1'b1;
      default: filtered = 1'b0;
    endcase
  end

  // Prefix FSM next-state and event generation
  always_comb begin
    next_state = state;
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_rel   = 1'b0;
    if (scancode_valid) begin
      if (filtered) begin
        next_state = IDLE;
      end else if (scancode == 8'hE0) begin
        next_state = GOT_E0;
      end else if (scancode == 8'hF0) begin
        next_state = (state == GOT_E0) ? GOT_E0F0 : GOT_F0;
      end else begin
        next_state = IDLE;
        emit       = 1'b1;
        emit_ext   = (state == GOT_E0) || (state == GOT_E0F0);
        emit_rel   = (state == GOT_F0) || (state == GOT_E0F0);
      end
    end else if ((state != IDLE) && (to_cnt == TO_LAST)) begin
      next_state = IDLE;
    end
  end

  // State, pending flag and prefix timeout counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      pending <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= next_state;
      pending <= (next_state != IDLE);
      if (scancode_valid || (state == IDLE)) to_cnt <= '0;
      else                                   to_cnt <= to_cnt + 1'b1;
    end
  end

  assign full    = (fifo_count == CNT_FULL);
  assign push    = emit;
  assign pop     = event_valid & event_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok = push & (~full | pop);

  // Event storage (no reset needed: reads are gated by event_valid)
  always_ff @(posedge clock) begin
    if (!reset && push_ok) mem[wr_ptr] <= {scancode, emit_ext, emit_rel};
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push && !push_ok) overflow <= 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Head presentation, forced to zero while empty
  always_comb begin
    event_valid = (fifo_count != '0);
    if (event_valid) {event_code, event_extended, event_released} = mem[rd_ptr];
    else             {event_code, event_extended, event_released} = '0;
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Testbench for ps2_scancode_decoder: byte-sequence table plus targeted
// sequences, with expected events scored through a queue.
module tb_ps2_scancode_decoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 20;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  scancode;
  logic        scancode_valid;
  logic [7:0]  event_code;
  logic        event_extended;
  logic        event_released;
  logic        event_valid;
  logic        event_ready;
  logic [2:0]  fifo_count;
  logic        pending;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  logic [9:0] sb [$];

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .scancode(scancode), .scancode_valid(scancode_valid),
    .event_code(event_code), .event_extended(event_extended), .event_released(event_released),
    .event_valid(event_valid), .event_ready(event_ready), .fifo_count(fifo_count),
    .pending(pending), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] b;
    bit         emit;
    logic [7:0] code;
    bit         ext;
    bit         rel;
    bit         pend;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Score every accepted head against the queue of expected events
  always @(negedge clock) begin
    if (!reset && event_valid && event_ready) begin
      logic [9:0] exp;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got=%h/%b/%b expected=none",
                 event_code, event_extended, event_released);
      end else begin
        exp = sb.pop_front();
        if ({event_code, event_extended, event_released} !== exp) begin
          errors++;
          $display("FAIL event: got=%h/%b/%b expected=%h/%b/%b",
                   event_code, event_extended, event_released, exp[9:2], exp[1], exp[0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    scancode = b;
    scancode_valid = 1'b1;
    @(posedge clock); #1;
    scancode_valid = 1'b0;
  endtask

  task automatic expect_ev(input logic [7:0] c, input bit e, input bit r);
    sb.push_back({c, e, r});
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    scancode_valid = 1'b1;
    scancode = 8'h1C;
    @(posedge clock); #1;
    scancode_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n = 0;
    while ((sb.size() != 0 || event_valid) && n < max_cycles) begin
      @(posedge clock); #1;
      n++;
    end
    check({name, "_drain_timeout"}, (n >= max_cycles) ? 1 : 0, 0);
  endtask

  vec_t vecs[] ;

  initial begin
    reset = 1'b1;
    scancode = 8'h00;
    scancode_valid = 1'b0;
    event_ready = 1'b1;

    vecs = '{
      '{8'h1C, 1, 8'h1C, 0, 0, 0},
      '{8'hF0, 0, 8'h00, 0, 0, 1},
      '{8'h1C, 1, 8'h1C, 0, 1, 0},
      '{8'hE0, 0, 8'h00, 0, 0, 1},
      '{8'hF0, 0, 8'h00, 0, 0, 1},
      '{8'h75, 1, 8'h75, 1, 1, 0},
      '{8'hE0, 0, 8'h00, 0, 0, 1},
      '{8'hE0, 0, 8'h00, 0, 0, 1},
      '{8'h6B, 1, 8'h6B, 1, 0, 0},
      '{8'hF0, 0, 8'h00, 0, 0, 1},
      '{8'hF0, 0, 8'h00, 0, 0, 1},
      '{8'hE0, 0, 8'h00, 0, 0, 1},
      '{8'h74, 1, 8'h74, 1, 0, 0},
      '{8'hE0, 0, 8'h00, 0, 0, 1},
      '{8'hF0, 0, 8'h00, 0, 0, 1},
      '{8'hF0, 0, 8'h00, 0, 0, 1},
      '{8'h12, 1, 8'h12, 0, 1, 0},
      '{8'hE0, 0, 8'h00, 0, 0, 1},
      '{8'hF0, 0, 8'h00, 0, 0, 1},
      '{8'hE0, 0, 8'h00, 0, 0, 1},
      '{8'h14, 1, 8'h14, 1, 0, 0},
      '{8'hE0, 0, 8'h00, 0, 0, 1},
      '{8'hFA, 0, 8'h00, 0, 0, 0},
      '{8'h29, 1, 8'h29, 0, 0, 0},
      '{8'hF0, 0, 8'h00, 0, 0, 1},
      '{8'hAA, 0, 8'h00, 0, 0, 0},
      '{8'h5A, 1, 8'h5A, 0, 0, 0},
      '{8'hE1, 0, 8'h00, 0, 0, 0},
      '{8'h77, 1, 8'h77, 0, 0, 0},
      '{8'h00, 0, 8'h00, 0, 0, 0},
      '{8'hFF, 0, 8'h00, 0, 0, 0}
    };

    repeat (3) @(posedge clock);
    #1;
    check("reset_valid",    event_valid, 0);
    check("reset_code",     event_code, 0);
    check("reset_count",    fifo_count, 0);
    check("reset_pending",  pending, 0);
    check("reset_overflow", overflow, 0);
    reset = 1'b0;

    // Single make code: visible the cycle after the strobe, then consumed
    expect_ev(8'h1C, 0, 0);
    send_byte(8'h1C);
    check("lat_valid", event_valid, 1);
    check("lat_code",  event_code, 8'h1C);
    check("lat_flags", {event_extended, event_released}, 2'b00);
    @(posedge clock); #1;
    check("lat_count_after_pop", fifo_count, 0);

    // Table of byte sequences across every prefix transition
    foreach (vecs[i]) begin
      if (vecs[i].emit) expect_ev(vecs[i].code, vecs[i].ext, vecs[i].rel);
      send_byte(vecs[i].b);
      check($sformatf("tbl_pending[%0d]", i), pending, vecs[i].pend);
      check($sformatf("tbl_valid[%0d]", i), event_valid, vecs[i].emit);
    end
    wait_drain("table", 20);

    // Lone E0 abandoned: times out with no event, next byte is a plain make
    send_byte(8'hE0);
    check("to_pending_set", pending, 1);
    repeat (TO - 1) @(posedge clock);
    #1;
    check("to_pending_before_limit", pending, 1);
    repeat (3) @(posedge clock);
    #1;
    check("to_pending_cleared", pending, 0);
    check("to_no_event", event_valid, 0);
    expect_ev(8'h75, 0, 0);
    send_byte(8'h75);
    wait_drain("timeout", 10);

    // Fill with consumer stalled; fifth event is dropped
    event_ready = 1'b0;
    expect_ev(8'h15, 0, 0); send_byte(8'h15);
    expect_ev(8'h1D, 0, 0); send_byte(8'h1D);
    expect_ev(8'h24, 0, 0); send_byte(8'h24);
    expect_ev(8'h2D, 0, 0); send_byte(8'h2D);
    check("full_overflow_clear", overflow, 0);
    send_byte(8'h2C);
    check("full_count", fifo_count, 4);
    check("full_overflow", overflow, 1);
    check("full_head", event_code, 8'h15);
    event_ready = 1'b1;
    wait_drain("overflow", 20);
    check("overflow_sticky", overflow, 1);

    // Full FIFO, simultaneous pop and push keeps occupancy and loses nothing
    do_reset();
    check("rst_overflow_cleared", overflow, 0);
    event_ready = 1'b0;
    expect_ev(8'h15, 0, 0); send_byte(8'h15);
    expect_ev(8'h1D, 0, 0); send_byte(8'h1D);
    expect_ev(8'h24, 0, 0); send_byte(8'h24);
    expect_ev(8'h2D, 0, 0); send_byte(8'h2D);
    check("pp_full", fifo_count, 4);
    @(posedge clock); #1;
    event_ready = 1'b1;
    scancode = 8'h3C;
    scancode_valid = 1'b1;
    expect_ev(8'h3C, 0, 0);
    @(posedge clock); #1;
    scancode_valid = 1'b0;
    check("pp_count", fifo_count, 4);
    check("pp_overflow", overflow, 0);
    wait_drain("pushpop", 20);

    // Filtered bytes, then reset mid-prefix discards everything
    send_byte(8'hAA);
    send_byte(8'hFA);
    check("filt_no_event", event_valid, 0);
    send_byte(8'hE0);
    check("filt_pending", pending, 1);
    do_reset();
    check("mid_rst_count",   fifo_count, 0);
    check("mid_rst_pending", pending, 0);
    check("mid_rst_valid",   event_valid, 0);
    expect_ev(8'h75, 0, 0);
    send_byte(8'h75);
    check("post_rst_flags", {event_extended, event_released}, 2'b00);
    wait_drain("post_reset", 10);

    check("final_queue_empty", sb.size(), 0);
    check("final_count", fifo_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
